// File: rtl/block_fetch_sequencer.sv
// block_fetch_sequencer: walks consecutive 64-word pixel blocks from memory,
// issuing one read per cycle, assembles each block into an 8x8 array and
// hands it to the DCT/quant stage over a valid/ready handshake.
module block_fetch_sequencer #(
   parameter int ADDR_WIDTH    = 12,
   parameter int DATA_WIDTH    = 32,
   parameter int MAX_BLOCK_NUM = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_offset,
   input  logic [5:0]            block_count,
   output logic                  busy,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  output_valid,
   input  logic                  output_ready,
   output logic [4:0]            output_block_index,
   output logic [DATA_WIDTH-1:0] output_data_array [8][8],
   output logic                  done
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_DRAIN = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [5:0] MAX_CNT = 6'(MAX_BLOCK_NUM);

   state_t                state_r, state_s;
   logic [ADDR_WIDTH-1:0] base_r, base_s;
   logic [5:0]            cnt_r, cnt_s;
   logic [4:0]            blk_r, blk_s;
   logic [5:0]            pix_r, pix_s;       // pixel index of the read currently on the bus
   logic                  busy_s;
   logic                  rd_en_s;
   logic [ADDR_WIDTH-1:0] rd_addr_s;
   logic                  valid_s;
   logic [4:0]            idx_s;
   logic                  done_s;
   logic [5:0]            clamp_s;
   logic                  cap_en_r;           // read data arrives this cycle
   logic [5:0]            cap_pix_r;          // destination pixel for that data

   // Word address of pixel pix of block blk; the add wraps at the memory size.
   function automatic logic [ADDR_WIDTH-1:0] blk_addr(
      input logic [ADDR_WIDTH-1:0] base,
      input logic [4:0]            blk,
      input logic [5:0]            pix
   );
      return base + ADDR_WIDTH'({blk, pix});
   endfunction

   // Block count limited to the maximum run length.
   always_comb begin
      if (block_count > MAX_CNT) begin
         clamp_s = MAX_CNT;
      end else begin
         clamp_s = block_count;
      end
   end

   // Next-state and next-output logic of the sequencing FSM.
   always_comb begin
      state_s   = state_r;
      base_s    = base_r;
      cnt_s     = cnt_r;
      blk_s     = blk_r;
      pix_s     = pix_r;
      busy_s    = busy;
      rd_en_s   = 1'b0;
      rd_addr_s = mem_rd_addr;
      valid_s   = output_valid;
      idx_s     = output_block_index;
      done_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               base_s = base_offset;
               cnt_s  = clamp_s;
               blk_s  = 5'd0;
               pix_s  = 6'd0;
               busy_s = 1'b1;
               if (clamp_s == 6'd0) begin
                  state_s = ST_DONE;
                  done_s  = 1'b1;
               end else begin
                  state_s   = ST_FETCH;
                  rd_en_s   = 1'b1;
                  rd_addr_s = blk_addr(base_offset, 5'd0, 6'd0);
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (pix_r == 6'd63) begin
               state_s = ST_DRAIN;
            end else begin
               pix_s     = pix_r + 6'd1;
               rd_en_s   = 1'b1;
               rd_addr_s = blk_addr(base_r, blk_r, pix_r + 6'd1);
            end
         end
         ST_DRAIN: begin
            // last pixel lands on this edge, so the block is complete
            valid_s = 1'b1;
            idx_s   = blk_r;
            state_s = ST_HOLD;
         end
         ST_HOLD: begin
            if (output_valid && output_ready) begin
               valid_s = 1'b0;
               if ({1'b0, blk_r} == (cnt_r - 6'd1)) begin
                  state_s = ST_DONE;
                  done_s  = 1'b1;
               end else begin
                  blk_s     = blk_r + 5'd1;
                  pix_s     = 6'd0;
                  state_s   = ST_FETCH;
                  rd_en_s   = 1'b1;
                  rd_addr_s = blk_addr(base_r, blk_r + 5'd1, 6'd0);
               end
            end else begin
               state_s = ST_HOLD;
            end
         end
         ST_DONE: begin
            busy_s  = 1'b0;
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
            valid_s = 1'b0;
         end
      endcase
   end

   // State, latched run configuration and registered control outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r            <= ST_IDLE;
         base_r             <= '0;
         cnt_r              <= 6'd0;
         blk_r              <= 5'd0;
         pix_r              <= 6'd0;
         busy               <= 1'b0;
         mem_rd_en          <= 1'b0;
         mem_rd_addr        <= '0;
         output_valid       <= 1'b0;
         output_block_index <= 5'd0;
         done               <= 1'b0;
      end else begin
         state_r            <= state_s;
         base_r             <= base_s;
         cnt_r              <= cnt_s;
         blk_r              <= blk_s;
         pix_r              <= pix_s;
         busy               <= busy_s;
         mem_rd_en          <= rd_en_s;
         mem_rd_addr        <= rd_addr_s;
         output_valid       <= valid_s;
         output_block_index <= idx_s;
         done               <= done_s;
      end
   end

   // Capture pipeline: one cycle behind each read, write the data into the block.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cap_en_r  <= 1'b0;
         cap_pix_r <= 6'd0;
         for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
               output_data_array[r][c] <= '0;
            end
         end
      end else begin
         cap_en_r  <= mem_rd_en;
         cap_pix_r <= pix_r;
         if (cap_en_r) begin
            output_data_array[cap_pix_r[5:3]][cap_pix_r[2:0]] <= mem_rd_data;
         end
      end
   end

endmodule

// File: tb/tb_block_fetch_sequencer.sv
// Self-checking bench for block_fetch_sequencer: a table of directed runs, a
// reset-abort sequence and random runs, all judged by a block-level model.
module tb_block_fetch_sequencer;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int MEMSZ = 4096;
   localparam int BUDGET = 6000;

   logic           clock = 1'b0;
   logic           reset;
   logic           start;
   logic [AW-1:0]  base_offset;
   logic [5:0]     block_count;
   logic           busy;
   logic           mem_rd_en;
   logic [AW-1:0]  mem_rd_addr;
   logic [DW-1:0]  mem_rd_data;
   logic           output_valid;
   logic           output_ready;
   logic [4:0]     output_block_index;
   logic [DW-1:0]  output_data_array [8][8];
   logic           done;

   int checks = 0;
   int errors = 0;
   logic [31:0] mem_key = 32'd0;

   block_fetch_sequencer dut (
      .clock(clock), .reset(reset), .start(start), .base_offset(base_offset),
      .block_count(block_count), .busy(busy), .mem_rd_en(mem_rd_en),
      .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .output_valid(output_valid), .output_ready(output_ready),
      .output_block_index(output_block_index),
      .output_data_array(output_data_array), .done(done)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      return {20'd0, a} ^ mem_key;
   endfunction

   // memory: data valid the cycle after the read strobe, garbage otherwise
   always @(posedge clock) begin
      if (mem_rd_en) mem_rd_data <= mem_word(mem_rd_addr);
      else           mem_rd_data <= 32'hDEAD_BEEF;
   end

   // model: pixel (j,k) of block blk of a run starting at b
   function automatic logic [31:0] exp_pix(input logic [AW-1:0] b, input int blk,
                                           input int j, input int k);
      int a;
      a = (int'(b) + 64 * blk + 8 * j + k) % MEMSZ;
      return mem_word(AW'(a));
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic int nonzero_pixels();
      int n = 0;
      for (int j = 0; j < 8; j++)
         for (int k = 0; k < 8; k++)
            if (output_data_array[j][k] !== 32'd0) n++;
      return n;
   endfunction

   // one run: drive start, monitor every cycle against the model
   task automatic do_run(input logic [AW-1:0] b, input logic [5:0] n, input int mode,
                         input int extra, input int exp_blocks, input int exp_reads);
      logic [AW-1:0] addr_q[$];
      logic [DW-1:0] prev_arr [8][8];
      logic [4:0]    prev_idx;
      logic          prev_valid, prev_hs, finished, found;
      int nb, cyc, reads, blocks, dones, first_read, first_valid, done_cyc;
      int stall, stab_err, busy_bad, fj, fk;
      nb = (int'(n) > 32) ? 32 : int'(n);
      for (int bb = 0; bb < nb; bb++)
         for (int p = 0; p < 64; p++)
            addr_q.push_back(AW'((int'(b) + 64 * bb + p) % MEMSZ));
      reads = 0; blocks = 0; dones = 0; first_read = -1; first_valid = -1;
      done_cyc = -1; stall = 0; stab_err = 0; busy_bad = 0;
      prev_valid = 1'b0; prev_hs = 1'b0; finished = 1'b0; prev_idx = 5'd0;
      @(negedge clock);
      start = 1'b1; base_offset = b; block_count = n;
      @(negedge clock);
      start = 1'b0;
      base_offset = AW'($urandom);
      block_count = 6'($urandom);
      cyc = 1;
      while (cyc <= BUDGET && !finished) begin
         case (mode)
            1:       output_ready = 1'($urandom_range(0, 1));
            2: begin
               if (output_valid && output_block_index == 5'd1 && stall < 10) begin
                  output_ready = 1'b0;
                  stall++;
               end else begin
                  output_ready = 1'b1;
               end
            end
            default: output_ready = 1'b1;
         endcase
         start = (cyc == extra);
         if (cyc == extra) begin
            base_offset = AW'($urandom);
            block_count = 6'd5;
         end
         if (mem_rd_en) begin
            reads++;
            if (first_read < 0) first_read = cyc;
            if (addr_q.size() == 0) chk("extra_read_addr", mem_rd_addr, 64'hFFFF);
            else chk($sformatf("rd_addr_%0d", reads - 1), mem_rd_addr, addr_q.pop_front());
         end
         if (prev_valid && output_valid && !prev_hs) begin
            if (output_block_index !== prev_idx) stab_err++;
            for (int j = 0; j < 8; j++)
               for (int k = 0; k < 8; k++)
                  if (output_data_array[j][k] !== prev_arr[j][k]) stab_err++;
         end
         if (output_valid) begin
            if (first_valid < 0) first_valid = cyc;
            prev_idx = output_block_index;
            prev_arr = output_data_array;
         end
         if (output_valid && output_ready) begin
            chk($sformatf("blk_index_%0d", blocks), output_block_index, blocks);
            found = 1'b0; fj = 0; fk = 0;
            for (int j = 0; j < 8; j++)
               for (int k = 0; k < 8; k++)
                  if (!found && output_data_array[j][k] !== exp_pix(b, blocks, j, k)) begin
                     found = 1'b1; fj = j; fk = k;
                  end
            chk($sformatf("blk%0d_arr_%0d_%0d", blocks, fj, fk),
                output_data_array[fj][fk], exp_pix(b, blocks, fj, fk));
            blocks++;
         end
         if (done) begin
            dones++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if ((done_cyc < 0 || cyc == done_cyc) && !busy) busy_bad++;
         if (done_cyc >= 0 && cyc == done_cyc + 1) begin
            chk("busy_after_done", busy, 1'b0);
            finished = 1'b1;
         end
         prev_valid = output_valid;
         prev_hs = output_valid && output_ready;
         @(negedge clock);
         cyc++;
      end
      start = 1'b0;
      output_ready = 1'b1;
      if (!finished) begin
         chk("run_timeout", 64'd0, 64'd1);
         reset = 1'b1;
         @(negedge clock);
         reset = 1'b0;
      end
      chk("blocks_presented", blocks, exp_blocks);
      chk("read_cycles", reads, exp_reads);
      chk("done_pulses", dones, 1);
      chk("addrs_left", addr_q.size(), 0);
      chk("hold_stability", stab_err, 0);
      chk("busy_during_run", busy_bad, 0);
      if (nb > 0) begin
         chk("first_read_cycle", first_read, 1);
         chk("first_valid_cycle", first_valid, 66);
      end else begin
         chk("zero_run_done_cycle", done_cyc, 1);
      end
      if (mode == 0) chk("done_cycle", done_cyc, 66 * nb + 1);
   endtask

   typedef struct {
      logic [AW-1:0] base;
      logic [5:0]    count;
      int            mode;
      int            extra;
      logic [31:0]   key;
      int            exp_blocks;
      int            exp_reads;
   } vec_t;

   vec_t vecs [6];

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dn;
      logic [AW-1:0] rb;
      logic [5:0] rn;
      vecs[0] = '{12'd100,  6'd1,  0, 0,  32'h0,         1,  64};
      vecs[1] = '{12'd0,    6'd3,  2, 0,  32'h0,         3,  192};
      vecs[2] = '{12'd4064, 6'd2,  0, 0,  32'h0,         2,  128};
      vecs[3] = '{12'd5,    6'd0,  0, 0,  32'h0,         0,  0};
      vecs[4] = '{12'd200,  6'd2,  0, 20, 32'h0,         2,  128};
      vecs[5] = '{12'd7,    6'd40, 1, 0,  32'hA5A5_5A5A, 32, 2048};

      reset = 1'b1; start = 1'b0; base_offset = '0; block_count = 6'd0;
      output_ready = 1'b0;
      #12;
      chk("rst_busy", busy, 1'b0);
      chk("rst_rd_en", mem_rd_en, 1'b0);
      chk("rst_rd_addr", mem_rd_addr, 12'd0);
      chk("rst_valid", output_valid, 1'b0);
      chk("rst_index", output_block_index, 5'd0);
      chk("rst_done", done, 1'b0);
      chk("rst_array_nonzero", nonzero_pixels(), 0);
      @(negedge clock);
      reset = 1'b0;
      output_ready = 1'b1;

      for (int v = 0; v < 6; v++) begin
         mem_key = vecs[v].key;
         do_run(vecs[v].base, vecs[v].count, vecs[v].mode, vecs[v].extra,
                vecs[v].exp_blocks, vecs[v].exp_reads);
      end

      // reset in the middle of a fetch aborts the run immediately
      mem_key = 32'h0;
      @(negedge clock);
      start = 1'b1; base_offset = 12'd300; block_count = 6'd2;
      @(negedge clock);
      start = 1'b0;
      repeat (29) @(negedge clock);
      chk("pre_reset_fetching", mem_rd_en, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_rd_en", mem_rd_en, 1'b0);
      chk("abort_rd_addr", mem_rd_addr, 12'd0);
      chk("abort_valid", output_valid, 1'b0);
      chk("abort_index", output_block_index, 5'd0);
      chk("abort_array_nonzero", nonzero_pixels(), 0);
      dn = 0;
      repeat (3) begin
         @(negedge clock);
         if (done) dn++;
      end
      reset = 1'b0;
      repeat (3) begin
         @(negedge clock);
         if (done || busy) dn++;
      end
      chk("abort_no_done", dn, 0);
      do_run(12'd64, 6'd1, 0, 0, 1, 64);

      // random runs with random backpressure
      for (int r = 0; r < 4; r++) begin
         mem_key = $urandom;
         rb = AW'($urandom);
         rn = 6'($urandom_range(0, 40));
         dn = (int'(rn) > 32) ? 32 : int'(rn);
         do_run(rb, rn, 1, 0, dn, 64 * dn);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/block_fetch_sequencer.md
Name: block_fetch_sequencer

Overview:
- Controller that sequences 8x8 pixel-block fetches from the shared 4096-word coefficient/pixel memory for the encoder front end.
- On a start pulse it walks block_count consecutive 64-word blocks from base_offset.
- It issues one memory read per cycle and assembles each block into an 8x8 array.
- It presents each block to the downstream DCT/quant stage with a valid/ready handshake.

Parameters:
ADDR_WIDTH, 12, memory word-address width (4096 words)
DATA_WIDTH, 32, memory/pixel word width
MAX_BLOCK_NUM, 32, maximum blocks per run; block_count is clamped to this

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle run request; sampled only in IDLE
base_offset  input  ADDR_WIDTH  word address of block 0; latched on accepted start
block_count  input  6  blocks in run (0..63); latched on accepted start
busy  output  1  high from accepted start until the cycle after done
mem_rd_en  output  1  memory read strobe
mem_rd_addr  output  ADDR_WIDTH  memory read address
mem_rd_data  input  DATA_WIDTH  read data, valid the cycle after mem_rd_en
output_valid  output  1  output_data_array holds a complete block
output_ready  input  1  downstream accepts block
output_block_index  output  5  index of presented block within run
output_data_array  output  DATA_WIDTH  unpacked [8][8] block, [row][col]
done  output  1  one-cycle pulse after last block accepted

Behaviour:
- Reset (async, immediate): state=IDLE; busy, mem_rd_en, output_valid and done are 0; mem_rd_addr is 0; output_block_index is 0; all 64 array entries are 0; latched config is cleared. Reset mid-run aborts the run with no done pulse.
- All outputs are registered.
- FSM states: IDLE, FETCH, DRAIN, HOLD, DONE.
- IDLE:
  - start=1 latches base_offset and cnt=min(block_count, MAX_BLOCK_NUM); blk=0, p=0; busy<=1.
  - If cnt==0, go to DONE with no reads. Otherwise go to FETCH.
- FETCH:
  - mem_rd_en=1 each cycle.
  - mem_rd_addr = (base + blk*64 + p) mod 2^ADDR_WIDTH; p increments each cycle.
  - After issuing p=63, go to DRAIN.
- Capture: data for read p arrives the cycle after issue and is written to output_data_array[p/8][p%8]. The capture pipeline runs in FETCH and DRAIN.
- DRAIN (1 cycle): captures pixel 63, then output_valid<=1, output_block_index<=blk, go to HOLD.
- Latency: start-sampling edge = E0. Reads are issued in cycles 1..64. output_valid rises at edge E65.
- HOLD:
  - output_valid stays 1; array and index are stable until the handshake.
  - On output_valid && output_ready at an edge: output_valid<=0.
  - If blk==cnt-1, go to DONE. Else blk++, p=0, and return to FETCH (next read in the following cycle).
- DONE (1 cycle): done=1. Then busy<=0 and state returns to IDLE.
- start is ignored in every state except IDLE.
- output_ready is ignored when output_valid=0.
- Array contents are not cleared between blocks; they are overwritten progressively during FETCH while output_valid=0.
- Address arithmetic: full-width add truncated to ADDR_WIDTH (wrap-around). No error is flagged on wrap.
- block_count changes after start have no effect until the next run.

Test Plan:
1. Memory mem[a]=a, base_offset=100, block_count=1, output_ready=1 -> output_valid rises at E65; array[j][k]=100+8j+k; index 0; handshake at E66; done=1 in the following cycle; busy low after.
2. base_offset=0, block_count=3, output_ready low for 10 cycles while block 1 is presented -> array and index 1 stay stable for 10 cycles. Indices appear 0,1,2 with array[0][0]=0,64,128. Exactly 192 mem_rd_en cycles; one done pulse.
3. base_offset=4064, block_count=2 -> block 0 reads 4064..4095 then 0..31. Block 1 reads addresses 32..95; block-1 array[0][0]=32.
4. block_count=0 -> done pulses the cycle after the start edge; mem_rd_en never asserts. A start pulse at cycle 20 of a 2-block run is ignored: the run ends with exactly 128 reads.
5. reset asserted at cycle 30 of FETCH -> all outputs and array read 0 immediately. After release, start with base_offset=64 -> block 0 array[0][0]=64.
6. block_count=40 -> clamped to 32 blocks; last output_block_index=31; 2048 reads; then done.
